pwm_multi_ch: RTL

Parametrised multi-channel PWM generator and the successor to our single-counter, three-output PWM block. One shared prescaler and period counter drive CH independent compare channels. Each channel has a per-channel polarity and enable, and a double-buffered duty register. Edge-aligned and center-aligned counting are selectable, and duty, period and mode changes apply glitch-free at period boundaries. It sits between the register/config logic and the output pads.

---
 rtl/pwm_multi_ch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator.
// One shared prescaler and period counter drive CH compare channels.
// Each channel has its own polarity, enable and double-buffered duty register.
// Period, mode and duty changes take effect only at period boundaries.
module pwm_multi_ch #(
   parameter int CH = 4,
   parameter int CW = 8,
   parameter int PW = 16,
   localparam int WCH = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic [PW-1:0]  prescale,
   input  logic [CW-1:0]  period,
   input  logic           center,
   input  logic           wr_en,
   input  logic [WCH-1:0] wr_ch,
   input  logic [CW-1:0]  wr_duty,
   input  logic [CH-1:0]  ch_en,
   input  logic [CH-1:0]  ch_pol,
   output logic [CH-1:0]  pwm_out,
   output logic           period_tick
);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [PW-1:0] P_ONE = PW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [CW-1:0] cnt;
   dir_t          dir;
   logic [CW-1:0] period_a;
   logic          center_a;
   logic [CW-1:0] duty_s [CH];
   logic [CW-1:0] duty_a [CH];
   logic          boundary;
   logic          bnd_q;
   logic [CH-1:0] raw;

   // Counter-advance strobe; >= lets a lowered prescale wrap immediately.
   always_comb begin
      tick = ena && (pre_cnt >= prescale);
   end

   // Prescaler: counts 0..prescale while running, frozen when ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (ena) begin
         if (tick) pre_cnt <= '0;
         else      pre_cnt <= pre_cnt + P_ONE;
      end
   end

   // Boundary: the tick on which cnt returns to 0 for the active mode.
   always_comb begin
      boundary = 1'b0;
      if (tick) begin
         if (period_a == '0)
            boundary = 1'b1;
         else if (!center_a)
            boundary = (cnt == period_a);
         else if (dir == DIR_DOWN)
            boundary = (cnt == C_ONE);
         else
            boundary = (cnt == period_a) && (period_a <= C_ONE);
      end
   end

   // Period counter and direction, plus the boundary-loaded period/mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         dir      <= DIR_UP;
         period_a <= '0;
         center_a <= 1'b0;
      end else if (boundary) begin
         cnt      <= '0;
         dir      <= DIR_UP;
         period_a <= period;
         center_a <= center;
      end else if (tick) begin
         if (!center_a) begin
            cnt <= cnt + C_ONE;
         end else if (dir == DIR_UP) begin
            if (cnt == period_a) begin
               dir <= DIR_DOWN;
               cnt <= cnt - C_ONE;
            end else begin
               cnt <= cnt + C_ONE;
            end
         end else begin
            cnt <= cnt - C_ONE;
         end
      end
   end

   // Duty shadow writes and boundary transfer; a write in the boundary
   // cycle lands in duty_s only, duty_a takes the pre-write value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH; i++) begin
            duty_s[i] <= '0;
            duty_a[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            if (wr_en && (wr_ch == i[WCH-1:0])) duty_s[i] <= wr_duty;
            if (boundary)                       duty_a[i] <= duty_s[i];
         end
      end
   end

   // Per-channel compare against the active duty.
   always_comb begin
      raw = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         raw[i] = (cnt < duty_a[i]);
      end
   end

   // Registered outputs; period_tick is delayed twice so it lines up with
   // the first pwm_out sample that reflects cnt=0 of the new period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_out     <= '0;
         bnd_q       <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= (ch_en & (raw ^ ch_pol)) | (~ch_en & ch_pol);
         bnd_q       <= boundary;
         period_tick <= bnd_q;
      end
   end

endmodule
